// File: rtl/fetch_pipe_param.sv
// Parametrised fetch stage: PC, synchronous IMEM request, 1-entry skid buffer and
// IF/ID register with valid bit, stall and redirect-with-squash support.
module fetch_pipe_param #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned FIELD_W  = 4,
  parameter int unsigned PC_STEP  = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [ADDR_W-1:0]    redirect_addr,
  output logic                 imem_en,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic [5*FIELD_W-1:0] imem_rdata,
  output logic                 id_valid,
  output logic [ADDR_W-1:0]    id_pc,
  output logic [ADDR_W-1:0]    id_next_pc,
  output logic [FIELD_W-1:0]   id_opcode,
  output logic [FIELD_W-1:0]   id_a,
  output logic [FIELD_W-1:0]   id_b,
  output logic [FIELD_W-1:0]   id_w,
  output logic [FIELD_W-1:0]   id_sign
);

  localparam int unsigned       INSTR_W = 5 * FIELD_W;
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               f_valid_q, f_valid_d;
  logic [ADDR_W-1:0]  f_pc_q, f_pc_d;
  logic               skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               id_valid_q, id_valid_d;
  logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic               req;

  always_comb begin
    req          = !stall_i && !redirect_i;
    pc_d         = pc_q;
    f_valid_d    = req;
    f_pc_d       = pc_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;

    if (redirect_i)    pc_d = redirect_addr;
    else if (!stall_i) pc_d = pc_q + STEP;

    // Redirect squashes everything in flight, even while decode is stalled.
    if (redirect_i) begin
      id_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!stall_i) begin
      if (skid_valid_q) begin
        id_valid_d   = 1'b1;
        id_pc_d      = skid_pc_q;
        id_instr_d   = skid_instr_q;
        skid_valid_d = 1'b0;
      end else begin
        id_valid_d   = f_valid_q;
        id_pc_d      = f_pc_q;
        id_instr_d   = imem_rdata;
      end
    end else if (f_valid_q) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = f_pc_q;
      skid_instr_d = imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= PC_RST;
      f_valid_q    <= 1'b0;
      f_pc_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      f_valid_q    <= f_valid_d;
      f_pc_q       <= f_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
    end
  end

  always_comb begin
    imem_en    = req;
    imem_addr  = pc_q;
    id_valid   = id_valid_q;
    id_pc      = id_pc_q;
    id_next_pc = id_pc_q + STEP;
    id_opcode  = id_instr_q[5*FIELD_W-1:4*FIELD_W];
    id_a       = id_instr_q[4*FIELD_W-1:3*FIELD_W];
    id_b       = id_instr_q[3*FIELD_W-1:2*FIELD_W];
    id_w       = id_instr_q[2*FIELD_W-1:FIELD_W];
    id_sign    = id_instr_q[FIELD_W-1:0];
  end

endmodule
